step_dir_sequencer: RTL and testbench

- Command-driven step/dir pulse generator feeding the external stepper driver pins and the on-chip microstepper step/dir inputs.
- Buffers move commands in a small FIFO and plays them back-to-back as timed step pulses.
- Inserts direction-setup delay on direction change; reports move completion and buffer space (MOVE_DONE / BUFFER_DTR).
- Sits between the SPI command state machine (producer) and the step/dir outputs.

---
 rtl/step_dir_sequencer_pkg.sv | 17 +
 rtl/step_dir_sequencer_if.sv | 28 ++
 rtl/step_dir_sequencer_cmd_fifo.sv | 56 +++++
 rtl/step_dir_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_step_dir_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_dir_sequencer_pkg.sv
// Shared widths and FSM encoding for the step/dir sequencer.
// Optional position counter is enabled by STEP_SEQ_POSITION_EN.
package step_dir_sequencer_pkg;

  localparam int DEF_DEPTH    = 4;
  localparam int DEF_STEP_W   = 32;
  localparam int DEF_PERIOD_W = 24;
  localparam int DEF_TIME_W   = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_DSETUP,
    SEQ_PHIGH,
    SEQ_PLOW
  } seq_state_e;

endpackage

// File: rtl/step_dir_sequencer_if.sv
// Move-command handshake from the SPI command block to the sequencer.
// Transfer happens when cmd_valid and cmd_ready are both high.
interface step_dir_sequencer_if
  import step_dir_sequencer_pkg::*;
#(
  parameter int STEP_W   = DEF_STEP_W,
  parameter int PERIOD_W = DEF_PERIOD_W
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [STEP_W-1:0]   cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir,
    output cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir,
    input  cmd_steps, cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/step_dir_sequencer_cmd_fifo.sv
// Command FIFO holding {dir, steps, period}; registered count.
// DEPTH must be a power of two so pointers wrap naturally.
module step_dir_sequencer_cmd_fifo
  import step_dir_sequencer_pkg::*;
#(
  parameter  int W     = 1 + DEF_STEP_W + DEF_PERIOD_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/step_dir_sequencer.sv
// Buffered step/dir pulse generator with direction setup delay.
// Define STEP_SEQ_POSITION_EN to add a signed step position output.
module step_dir_sequencer
  import step_dir_sequencer_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int TIME_W   = DEF_TIME_W
) (
  input  logic                clk,
  input  logic                reset,
  step_dir_sequencer_if.slave cmd,
  input  logic                enable,
  input  logic                halt,
  input  logic [TIME_W-1:0]   pulse_width,
  input  logic [TIME_W-1:0]   dir_setup,
  output logic                step,
  output logic                dir,
  output logic                move_done,
  output logic                buffer_dtr,
  output logic                busy,
  output logic [STEP_W-1:0]   steps_remaining
`ifdef STEP_SEQ_POSITION_EN
  ,
  output logic signed [31:0]  position
`endif
);

  localparam int FW = 1 + STEP_W + PERIOD_W;
  localparam int CW = $clog2(DEPTH);

  seq_state_e          state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] period_q, period_n;
  logic [PERIOD_W-1:0] hi, ds, lo;
  logic [PERIOD_W:0]   diff;
  logic [STEP_W-1:0]   rem_n, rd_steps;
  logic [PERIOD_W-1:0] rd_period;
  logic [FW-1:0]       rd_data;
  logic [CW:0]         count;
  logic rd_dir, full, empty;
  logic push, pop, flush, rise, last, abort;
  logic step_n, dir_n, done_n;

  assign cmd.cmd_ready = !full && !halt;
  assign buffer_dtr    = cmd.cmd_ready;
  assign push = cmd.cmd_valid && cmd.cmd_ready;
  assign busy = (state != SEQ_IDLE) || (count != '0);
  assign {rd_dir, rd_steps, rd_period} = rd_data;
  assign last = (cnt <= PERIOD_W'(1));

  step_dir_sequencer_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({cmd.cmd_dir, cmd.cmd_steps, cmd.cmd_period}),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Low time is computed one bit wider so short periods clamp to 1.
  always_comb begin
    hi = (pulse_width == '0) ? PERIOD_W'(1) : PERIOD_W'(pulse_width);
    ds = (dir_setup == '0) ? PERIOD_W'(1) : PERIOD_W'(dir_setup);
    diff = {1'b0, period_q} - {1'b0, hi};
    lo = (diff[PERIOD_W] || diff == '0) ?
         PERIOD_W'(1) : diff[PERIOD_W-1:0];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period_q;
    rem_n    = steps_remaining;
    step_n   = step;
    dir_n    = dir;
    done_n   = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    rise     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        if (halt) begin
          abort = 1'b1;
        end else if (enable && !empty) begin
          pop      = 1'b1;
          rem_n    = rd_steps;
          period_n = rd_period;
          if (rd_steps == '0) begin
            done_n = 1'b1;
          end else if (rd_dir != dir) begin
            dir_n   = rd_dir;
            state_n = SEQ_DSETUP;
            cnt_n   = ds;
          end else begin
            state_n = SEQ_PHIGH;
            step_n  = 1'b1;
            cnt_n   = hi;
            rise    = 1'b1;
          end
        end
      end
      SEQ_DSETUP: begin
        if (halt) begin
          abort = 1'b1;
        end else if (enable) begin
          if (last) begin
            state_n = SEQ_PHIGH;
            step_n  = 1'b1;
            cnt_n   = hi;
            rise    = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      // The high phase always runs to completion; halt lands afterwards.
      SEQ_PHIGH: begin
        if (last) begin
          step_n  = 1'b0;
          state_n = SEQ_PLOW;
          cnt_n   = lo;
          rem_n   = (steps_remaining != '0) ?
                    steps_remaining - 1'b1 : '0;
          abort   = halt;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SEQ_PLOW: begin
        if (halt) begin
          abort = 1'b1;
        end else if (enable) begin
          if (!last) begin
            cnt_n = cnt - 1'b1;
          end else if (steps_remaining == '0) begin
            done_n  = 1'b1;
            state_n = SEQ_IDLE;
          end else begin
            state_n = SEQ_PHIGH;
            step_n  = 1'b1;
            cnt_n   = hi;
            rise    = 1'b1;
          end
        end
      end
      default: state_n = SEQ_IDLE;
    endcase
    if (abort) begin
      state_n = SEQ_IDLE;
      flush   = 1'b1;
      rem_n   = '0;
      step_n  = 1'b0;
      done_n  = 1'b0;
      pop     = 1'b0;
      rise    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= SEQ_IDLE;
      cnt             <= '0;
      period_q        <= '0;
      steps_remaining <= '0;
      step            <= 1'b0;
      dir             <= 1'b0;
      move_done       <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      period_q        <= period_n;
      steps_remaining <= rem_n;
      step            <= step_n;
      dir             <= dir_n;
      move_done       <= done_n;
    end
  end

`ifdef STEP_SEQ_POSITION_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      position <= '0;
    else if (rise)
      position <= dir ? position + 32'sd1 : position - 32'sd1;
  end
`endif

endmodule

// File: tb/tb_step_dir_sequencer.sv
// Randomized bench for step_dir_sequencer against an event-timeline model.
// Build with STEP_SEQ_POSITION_EN to also check the position output.
module tb_step_dir_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        halt;
  logic [7:0]  pulse_width;
  logic [7:0]  dir_setup;
  logic        step;
  logic        dir;
  logic        move_done;
  logic        buffer_dtr;
  logic        busy;
  logic [31:0] steps_remaining;
`ifdef STEP_SEQ_POSITION_EN
  logic signed [31:0] position;
`endif

  step_dir_sequencer_if bus ();

  step_dir_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (bus),
    .enable          (enable),
    .halt            (halt),
    .pulse_width     (pulse_width),
    .dir_setup       (dir_setup),
    .step            (step),
    .dir             (dir),
    .move_done       (move_done),
    .buffer_dtr      (buffer_dtr),
    .busy            (busy),
    .steps_remaining (steps_remaining)
`ifdef STEP_SEQ_POSITION_EN
    ,
    .position        (position)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  typedef struct {
    bit d;
    int s;
    int p;
  } cmd_t;

  cmd_t cq[$];
  int exp_rise[$], exp_fall[$], exp_done[$];
  int exp_rdir[$], exp_rem[$];
  int obs_rise[$], obs_fall[$], obs_done[$];
  int obs_rdir[$], obs_rem[$];
  bit mdir;
  int mpos;

  // Index n below means "value visible after the n-th rising edge".
  bit pstep;
  always @(negedge clk) begin
    if (step && !pstep) begin
      obs_rise.push_back(cyc);
      obs_rdir.push_back(int'(dir));
      obs_rem.push_back(int'(steps_remaining));
    end
    if (!step && pstep) begin
      obs_fall.push_back(cyc);
      obs_rem.push_back(int'(steps_remaining));
    end
    if (move_done)
      obs_done.push_back(cyc);
    pstep = step;
  end

  task automatic clear();
    exp_rise.delete(); exp_fall.delete(); exp_done.delete();
    exp_rdir.delete(); exp_rem.delete();
    obs_rise.delete(); obs_fall.delete(); obs_done.delete();
    obs_rdir.delete(); obs_rem.delete();
  endtask

  // Timeline of pulses: first rise, then one per effective period.
  task automatic model(input int t0, input int pw, input int ds);
    int t, hi, dsu, r, per;
    t = t0;
    hi = (pw == 0) ? 1 : pw;
    dsu = (ds == 0) ? 1 : ds;
    foreach (cq[i]) begin
      if (cq[i].s == 0) begin
        exp_done.push_back(t);
        t = t + 1;
      end else begin
        r = t;
        if (cq[i].d != mdir) begin
          mdir = cq[i].d;
          r = t + dsu;
        end
        per = (cq[i].p > hi) ? cq[i].p : hi + 1;
        for (int k = 0; k < cq[i].s; k++) begin
          exp_rise.push_back(r + k * per);
          exp_fall.push_back(r + k * per + hi);
          exp_rdir.push_back(int'(mdir));
          exp_rem.push_back(cq[i].s - k);
          exp_rem.push_back(cq[i].s - k - 1);
          mpos += mdir ? 1 : -1;
        end
        exp_done.push_back(r + cq[i].s * per);
        t = r + cq[i].s * per + 1;
      end
    end
    cq.delete();
  endtask

  task automatic push(input bit d, input int s, input int p,
                      output int edge_no);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_dir    = d;
    bus.cmd_steps  = 32'(s);
    bus.cmd_period = 24'(p);
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500)
      check("push_wait", n, 0);
    @(posedge clk);
    #1;
    edge_no = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 5000);
    if (busy)
      check("idle_wait", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, " rises"}, obs_rise.size(), exp_rise.size());
    check({tag, " falls"}, obs_fall.size(), exp_fall.size());
    check({tag, " dones"}, obs_done.size(), exp_done.size());
    check({tag, " rems"}, obs_rem.size(), exp_rem.size());
    for (int i = 0; i < obs_rise.size() && i < exp_rise.size(); i++) begin
      check($sformatf("%s rise%0d", tag, i), obs_rise[i], exp_rise[i]);
      check($sformatf("%s dir%0d", tag, i), obs_rdir[i], exp_rdir[i]);
    end
    for (int i = 0; i < obs_fall.size() && i < exp_fall.size(); i++)
      check($sformatf("%s fall%0d", tag, i), obs_fall[i], exp_fall[i]);
    for (int i = 0; i < obs_rem.size() && i < exp_rem.size(); i++)
      check($sformatf("%s rem%0d", tag, i), obs_rem[i], exp_rem[i]);
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      check($sformatf("%s done%0d", tag, i), obs_done[i], exp_done[i]);
`ifdef STEP_SEQ_POSITION_EN
    check({tag, " pos"}, position, mpos);
`endif
  endtask

  task automatic run_batch(input string tag, input int pw, input int ds);
    int e, first;
    first = 0;
    clear();
    @(negedge clk);
    pulse_width = 8'(pw);
    dir_setup   = 8'(ds);
    foreach (cq[i]) begin
      push(cq[i].d, cq[i].s, cq[i].p, e);
      if (i == 0)
        first = e;
    end
    model(first + 1, pw, ds);
    wait_idle();
    compare(tag);
  endtask

  task automatic add(input bit d, input int s, input int p);
    cmd_t c;
    c.d = d;
    c.s = s;
    c.p = p;
    cq.push_back(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mdir = 1'b0;
    mpos = 0;
  endtask

  int e, p, n, acc;
  cmd_t c5;

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    halt = 1'b0;
    pulse_width = 8'd1;
    dir_setup = 8'd1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_period = '0;
    do_reset();

    @(negedge clk);
    check("rst step", step, 0);
    check("rst dir", dir, 0);
    check("rst done", move_done, 0);
    check("rst busy", busy, 0);
    check("rst rem", steps_remaining, 0);
    check("rst ready", bus.cmd_ready, 1);
    check("rst dtr", buffer_dtr, 1);
`ifdef STEP_SEQ_POSITION_EN
    check("rst pos", position, 0);
`endif

    add(1'b1, 3, 10);
    run_batch("basic", 2, 4);

    add(mdir, 0, 5);
    add(!mdir, 0, 5);
    run_batch("zero", 2, 3);

    add(1'b1, 2, 6);
    add(1'b0, 2, 6);
    run_batch("b2b", 1, 3);

    // Fill the FIFO while paused, then hold a fifth command.
    clear();
    @(negedge clk);
    enable = 1'b0;
    pulse_width = 8'd1;
    dir_setup = 8'd2;
    add(1'b1, 1, 3);
    add(1'b1, 0, 3);
    add(1'b0, 2, 4);
    add(1'b0, 1, 2);
    add(1'b1, 2, 3);
    for (int i = 0; i < 4; i++)
      push(cq[i].d, cq[i].s, cq[i].p, e);
    @(negedge clk);
    check("full ready", bus.cmd_ready, 0);
    check("full dtr", buffer_dtr, 0);
    c5 = cq[4];
    bus.cmd_valid = 1'b1;
    bus.cmd_dir = c5.d;
    bus.cmd_steps = 32'(c5.s);
    bus.cmd_period = 24'(c5.p);
    repeat (4) @(negedge clk);
    check("held ready", bus.cmd_ready, 0);
    enable = 1'b1;
    e = cyc;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
    check("fifth accept", acc, e + 2);
    model(e + 1, 1, 2);
    wait_idle();
    compare("fill");

    // Pause for three cycles during the low phase.
    clear();
    @(negedge clk);
    pulse_width = 8'd2;
    push(mdir, 2, 10, p);
    repeat (4) @(negedge clk);
    check("pause fell", step, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_idle();
    mpos += mdir ? 2 : -2;
    check("pause rises", obs_rise.size(), 2);
    check("pause dones", obs_done.size(), 1);
    if (obs_rise.size() >= 2) begin
      check("pause rise0", obs_rise[0], p + 1);
      check("pause rise1", obs_rise[1], p + 14);
    end
    if (obs_done.size() >= 1)
      check("pause done", obs_done[0], p + 24);

    // Halt during the first high phase of a long move.
    clear();
    @(negedge clk);
    pulse_width = 8'd4;
    dir_setup = 8'd2;
    push(mdir, 100, 8, p);
    push(!mdir, 5, 8, e);
    push(mdir, 5, 8, e);
    @(negedge clk);
    halt = 1'b1;
    check("halt high", step, 1);
    n = 0;
    while (step && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("halt fall", cyc, p + 5);
    check("halt busy", busy, 0);
    check("halt rem", steps_remaining, 0);
    check("halt ready", bus.cmd_ready, 0);
    halt = 1'b0;
    @(negedge clk);
    check("halt empty", bus.cmd_ready, 1);
    repeat (30) @(negedge clk);
    check("halt dones", obs_done.size(), 0);
    check("halt rises", obs_rise.size(), 1);
    mpos += mdir ? 1 : -1;
`ifdef STEP_SEQ_POSITION_EN
    check("halt pos", position, mpos);
`endif

    for (int b = 0; b < 10; b++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        add(1'($urandom_range(0, 1)), $urandom_range(0, 4),
            $urandom_range(0, 12));
      run_batch($sformatf("rnd%0d", b), $urandom_range(0, 3),
                $urandom_range(0, 5));
    end

    // Asynchronous reset while the step output is high.
    clear();
    @(negedge clk);
    pulse_width = 8'd4;
    push(mdir, 3, 10, p);
    repeat (2) @(negedge clk);
    check("ar high", step, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar step", step, 0);
    check("ar busy", busy, 0);
    check("ar rem", steps_remaining, 0);
    @(negedge clk);
    do_reset();
    repeat (2) @(negedge clk);

    add(1'b1, 5, 4);
    add(1'b0, 7, 4);
    run_batch("pos", 1, 2);
`ifdef STEP_SEQ_POSITION_EN
    check("pos net", position, -2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
